// File: rtl/rr_packet_mux_if.sv
// rr_packet_mux_if
//   Bundle of the packet-mux data-path signals.
//   Upstream side : req_valid / req_data / req_last  in, req_ready out.
//   Downstream side: out_valid / out_data / out_last / out_src out, out_ready in.
//   Status        : busy (mux currently locked onto one source's packet).
//   Modports:
//     slave  - the mux itself (consumes requests, produces output beats)
//     master - the environment around it (drives requests, absorbs output)
interface rr_packet_mux_if #(
  parameter int DATA_W = 8,
  parameter int N_REQ  = 3
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;

  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic                    out_last;
  logic [1:0]              out_src;
  logic                    out_ready;

  logic                    busy;

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src, busy
  );

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src, busy
  );

endinterface

// File: rtl/rr_packet_mux.sv
// rr_packet_mux
//   Merges three valid/ready packet streams (framed by a last-beat flag) onto
//   one registered output stream. A rotating one-hot priority ring picks the
//   next source at packet boundaries; once a multi-beat packet starts the
//   grant stays with that source until its last beat, even across bubbles.
//   The finishing source drops to lowest priority.
//
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous active-low reset
//     bus    - rr_packet_mux_if.slave:
//                req_valid/req_data/req_last in, req_ready out (one-hot or 0)
//                out_valid/out_data/out_last/out_src registered outputs
//                out_ready in, busy out (high while locked mid-packet)
module rr_packet_mux #(
  parameter int DATA_W = 8,
  parameter int N_REQ  = 3
) (
  input  logic             clk,
  input  logic             reset,
  rr_packet_mux_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Next source index around the three-entry ring.
  function automatic logic [1:0] idx_inc(input logic [1:0] idx);
    case (idx)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // prio_q is always one-hot; anything else falls back to source 0.
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    case (oh)
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Registered state
  state_t            state_q,     state_d;
  logic [1:0]        owner_q,     owner_d;
  logic [2:0]        prio_q,      prio_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_last_q,  out_last_d;
  logic [1:0]        out_src_q,   out_src_d;
  logic              busy_q,      busy_d;

  // Combinational helpers
  logic              can_load_s;
  logic [1:0]        start_idx_s;
  logic [1:0]        cand1_idx_s;
  logic [1:0]        cand2_idx_s;
  logic [1:0]        winner_idx_s;
  logic              winner_vld_s;
  logic [1:0]        grant_idx_s;
  logic              grant_vld_s;
  logic              accept_s;
  logic              beat_last_s;
  logic [DATA_W-1:0] beat_data_s;
  logic [N_REQ-1:0]  req_ready_s;

  // Rotating-priority search: start at the prio position, then walk upward with wrap.
  always_comb begin
    start_idx_s  = onehot_to_idx(prio_q);
    cand1_idx_s  = idx_inc(start_idx_s);
    cand2_idx_s  = idx_inc(cand1_idx_s);
    winner_idx_s = start_idx_s;
    winner_vld_s = 1'b0;
    if (bus.req_valid[start_idx_s]) begin
      winner_idx_s = start_idx_s;
      winner_vld_s = 1'b1;
    end else if (bus.req_valid[cand1_idx_s]) begin
      winner_idx_s = cand1_idx_s;
      winner_vld_s = 1'b1;
    end else if (bus.req_valid[cand2_idx_s]) begin
      winner_idx_s = cand2_idx_s;
      winner_vld_s = 1'b1;
    end else begin
      winner_idx_s = start_idx_s;
      winner_vld_s = 1'b0;
    end
  end

  // Grant selection, accept decision and beat mux from the granted source.
  always_comb begin
    can_load_s = !out_valid_q || bus.out_ready;

    // While locked only the owner may be served; its valid gap is a bubble.
    if (state_q == LOCKED) begin
      grant_idx_s = owner_q;
      grant_vld_s = bus.req_valid[owner_q];
    end else begin
      grant_idx_s = winner_idx_s;
      grant_vld_s = winner_vld_s;
    end

    // Gating with reset keeps req_ready low for the whole time reset is held,
    // not just after the flops have cleared.
    accept_s = grant_vld_s && can_load_s && reset;

    if (accept_s) begin
      req_ready_s = idx_to_onehot(grant_idx_s);
    end else begin
      req_ready_s = 3'b000;
    end

    beat_last_s = bus.req_last[grant_idx_s];
    case (grant_idx_s)
      2'd0:    beat_data_s = bus.req_data[0        +: DATA_W];
      2'd1:    beat_data_s = bus.req_data[DATA_W   +: DATA_W];
      default: beat_data_s = bus.req_data[2*DATA_W +: DATA_W];
    endcase
  end

  // Next-state for the packet FSM, priority ring and registered output slot.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;

    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = beat_data_s;
      out_last_d  = beat_last_s;
      out_src_d   = grant_idx_s;
      if (beat_last_s) begin
        // Packet done: the finishing source becomes lowest priority.
        state_d = IDLE;
        prio_d  = idx_to_onehot(idx_inc(grant_idx_s));
      end else begin
        state_d = LOCKED;
        owner_d = grant_idx_s;
      end
    end else if (bus.out_ready) begin
      // Slot drained with nothing new; data/last/src keep their last value.
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    busy_d = (state_d == LOCKED);
  end

  // State and output registers; reset drops everything including a partial packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      prio_q      <= 3'b001;
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_last_q  <= 1'b0;
      out_src_q   <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rr_packet_mux.sv
// tb_rr_packet_mux
//   Directed bench for rr_packet_mux. Inputs change 1 time unit after each
//   rising edge; combinational req_ready is checked 1 unit later; output beats
//   are taken from the falling edge whenever out_valid && out_ready and
//   compared against an expected-beat queue filled as stimulus is driven.
module tb_rr_packet_mux;

  localparam int DATA_W = 8;
  localparam int N_REQ  = 3;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  // Expected beat: {src[1:0], last, data[7:0]}
  logic [10:0] exp_q[$];

  rr_packet_mux_if #(.DATA_W(DATA_W), .N_REQ(N_REQ)) bus ();

  rr_packet_mux #(.DATA_W(DATA_W), .N_REQ(N_REQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [7:0] d, input logic l);
    bus.req_valid[i]            = v;
    bus.req_data[i*DATA_W +: DATA_W] = d;
    bus.req_last[i]             = l;
  endtask

  task automatic push_exp(input logic [1:0] src, input logic [7:0] data, input logic last);
    exp_q.push_back({src, last, data});
  endtask

  task automatic all_single(input logic v0, input logic v1, input logic v2);
    set_src(0, v0, 8'hA0, 1'b1);
    set_src(1, v1, 8'hB1, 1'b1);
    set_src(2, v2, 8'hC2, 1'b1);
  endtask

  task automatic monitor_loop();
    logic [10:0] obs_v;
    logic [10:0] exp_v;
    forever begin
      @(negedge clk);
      if (reset && bus.out_valid && bus.out_ready) begin
        obs_v = {bus.out_src, bus.out_last, bus.out_data};
        check("beat_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          check("out_beat", {21'd0, obs_v}, {21'd0, exp_v});
        end
      end
    end
  endtask

  initial begin
    logic [1:0] t1_src [4];
    logic [7:0] t1_dat [4];
    logic [2:0] t1_rdy [4];

    errors = 0;
    checks = 0;
    t1_src = '{2'd0, 2'd1, 2'd2, 2'd0};
    t1_dat = '{8'hA0, 8'hB1, 8'hC2, 8'hA0};
    t1_rdy = '{3'b001, 3'b010, 3'b100, 3'b001};

    reset         = 1'b1;
    bus.req_valid = 3'b000;
    bus.req_data  = '0;
    bus.req_last  = 3'b000;
    bus.out_ready = 1'b1;
    fork
      monitor_loop();
    join_none

    // Reset state, with all sources requesting.
    #2 reset = 1'b0;
    all_single(1'b1, 1'b1, 1'b1);
    step();
    step();
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, bus.out_data},  32'd0);
    check("rst_out_last",  {31'd0, bus.out_last},  32'd0);
    check("rst_out_src",   {30'd0, bus.out_src},   32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_req_ready", {29'd0, bus.req_ready}, 32'd0);
    check("rst_prio",      {29'd0, dut.prio_q},    32'd1);

    // Test 1: single-beat packets from all three, round-robin 0,1,2,0.
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("t1_req_ready", {29'd0, bus.req_ready}, {29'd0, t1_rdy[k]});
      push_exp(t1_src[k], t1_dat[k], 1'b1);
      step();
      check("t1_out_valid_cont", {31'd0, bus.out_valid}, 32'd1);
    end

    // Test 2: 4-beat packet on source 1 while 0 and 2 keep requesting.
    for (int k = 0; k < 4; k++) begin
      set_src(1, 1'b1, 8'h10 + 8'(k), (k == 3));
      settle();
      check("t2_req_ready", {29'd0, bus.req_ready}, 32'b010);
      push_exp(2'd1, 8'h10 + 8'(k), (k == 3));
      step();
      check("t2_busy", {31'd0, bus.busy}, (k == 3) ? 32'd0 : 32'd1);
    end
    set_src(1, 1'b0, 8'hB1, 1'b1);
    settle();
    check("t2_next_grant_src2", {29'd0, bus.req_ready}, 32'b100);
    push_exp(2'd2, 8'hC2, 1'b1);
    step();
    all_single(1'b0, 1'b0, 1'b0);
    step();
    step();

    // Test 3: source 0 packet with a 3-cycle valid gap; source 2 waiting.
    set_src(0, 1'b1, 8'h01, 1'b0);
    set_src(2, 1'b1, 8'hC2, 1'b1);
    settle();
    check("t3_first_grant", {29'd0, bus.req_ready}, 32'b001);
    push_exp(2'd0, 8'h01, 1'b0);
    step();
    set_src(0, 1'b0, 8'h01, 1'b0);
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t3_gap_busy",      {31'd0, bus.busy},      32'd1);
      check("t3_gap_req_ready", {29'd0, bus.req_ready}, 32'b000);
      step();
    end
    set_src(0, 1'b1, 8'h02, 1'b1);
    settle();
    check("t3_resume_grant", {29'd0, bus.req_ready}, 32'b001);
    push_exp(2'd0, 8'h02, 1'b1);
    step();
    set_src(0, 1'b0, 8'h02, 1'b1);
    settle();
    check("t3_then_src2", {29'd0, bus.req_ready}, 32'b100);
    push_exp(2'd2, 8'hC2, 1'b1);
    step();
    all_single(1'b0, 1'b0, 1'b0);
    step();
    step();

    // Test 4: 5 cycles of backpressure with a beat sitting in the output slot.
    all_single(1'b1, 1'b1, 1'b1);
    settle();
    push_exp(2'd0, 8'hA0, 1'b1);
    step();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("t4_hold_req_ready", {29'd0, bus.req_ready}, 32'b000);
      step();
      check("t4_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t4_hold_beat", {21'd0, bus.out_src, bus.out_last, bus.out_data}, {21'd0, 2'd0, 1'b1, 8'hA0});
    end
    bus.out_ready = 1'b1;
    settle();
    check("t4_release_grant", {29'd0, bus.req_ready}, 32'b010);
    push_exp(2'd1, 8'hB1, 1'b1);
    step();
    push_exp(2'd2, 8'hC2, 1'b1);
    step();
    push_exp(2'd0, 8'hA0, 1'b1);
    step();
    all_single(1'b0, 1'b0, 1'b0);
    step();
    step();

    // Test 5: reset while locked on source 2 mid-packet.
    set_src(2, 1'b1, 8'h20, 1'b0);
    settle();
    check("t5_grant_src2", {29'd0, bus.req_ready}, 32'b100);
    push_exp(2'd2, 8'h20, 1'b0);
    step();
    set_src(2, 1'b1, 8'h21, 1'b0);
    step();
    check("t5_locked_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b0;
    settle();
    check("t5_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t5_rst_busy",      {31'd0, bus.busy},      32'd0);
    check("t5_rst_prio",      {29'd0, dut.prio_q},    32'd1);
    check("t5_rst_req_ready", {29'd0, bus.req_ready}, 32'b000);
    step();
    step();
    reset = 1'b1;
    all_single(1'b1, 1'b1, 1'b1);
    settle();
    check("t5_post_rst_src0", {29'd0, bus.req_ready}, 32'b001);
    push_exp(2'd0, 8'hA0, 1'b1);
    step();
    all_single(1'b0, 1'b0, 1'b0);
    step();
    step();

    // Test 6: only source 2 requesting, single-beat packets every cycle.
    for (int k = 0; k < 4; k++) begin
      set_src(2, 1'b1, 8'h30 + 8'(k), 1'b1);
      settle();
      check("t6_req_ready", {29'd0, bus.req_ready}, 32'b100);
      push_exp(2'd2, 8'h30 + 8'(k), 1'b1);
      step();
      check("t6_prio", {29'd0, dut.prio_q}, 32'b001);
    end
    all_single(1'b0, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      step();
    end
    step();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("final_out_valid", {31'd0, bus.out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
